// File: rtl/laser_measure_scheduler.sv
// Laser distance meter sequencer: fires the meter, waits for the echo, accumulates
// 2**LOG2_NAVG shots and hands one averaged result to the host over valid/ready.
// A missing echo pulses meter_rst and returns an error result instead.
module laser_measure_scheduler #(
  parameter int DW        = 16,
  parameter int LOG2_NAVG = 2,
  parameter int TIMEOUT   = 65535,
  parameter int GAP       = 4,
  parameter int RST_CYC   = 2
) (
  input  logic          clk,
  input  logic          reset,
  input  logic          req_valid,
  output logic          req_ready,
  input  logic          cont,
  input  logic          sensor_s,
  input  logic [DW-1:0] meas_d,
  output logic          meter_b,
  output logic          meter_rst,
  output logic          res_valid,
  input  logic          res_ready,
  output logic [DW-1:0] res_dist,
  output logic          res_err,
  output logic          busy
);

  localparam int AW   = DW + LOG2_NAVG;
  localparam int NAVG = 1 << LOG2_NAVG;
  localparam int SW   = LOG2_NAVG + 1;
  localparam int TW   = $clog2(TIMEOUT + 1);
  localparam int GW   = $clog2(GAP + 1);
  localparam int RW   = $clog2(RST_CYC + 1);

  localparam logic [SW-1:0] LAST_SHOT = SW'(NAVG - 1);
  localparam logic [GW-1:0] GAP_LAST  = GW'(GAP - 1);
  localparam logic [RW-1:0] RST_LAST  = RW'(RST_CYC - 1);
  // to_cnt is 0 in the first WAIT_ECHO cycle; aborting at TIMEOUT-2 makes
  // meter_rst rise exactly TIMEOUT cycles after the meter_b pulse.
  localparam logic [TW-1:0] TO_LAST   = TW'(TIMEOUT - 2);

  typedef enum logic [2:0] {
    S_IDLE,
    S_ARM,
    S_WAIT_ECHO,
    S_CAPTURE,
    S_GAP,
    S_DONE,
    S_ERR_RST,
    S_ERR_HOLD
  } state_t;

  state_t        state;
  logic          cont_q;
  logic [AW-1:0] acc;
  logic [AW-1:0] acc_sum;
  logic [SW-1:0] shot_cnt;
  logic [TW-1:0] to_cnt;
  logic [GW-1:0] gap_cnt;
  logic [RW-1:0] rst_cnt;

  // Running sum including the shot being captured this cycle.
  always_comb begin
    acc_sum = acc + AW'(meas_d);
  end

  // Sequencer with all host/meter outputs registered alongside the state.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state     <= S_IDLE;
      cont_q    <= 1'b0;
      acc       <= '0;
      shot_cnt  <= '0;
      to_cnt    <= '0;
      gap_cnt   <= '0;
      rst_cnt   <= '0;
      req_ready <= 1'b1;
      meter_b   <= 1'b0;
      meter_rst <= 1'b0;
      res_valid <= 1'b0;
      res_dist  <= '0;
      res_err   <= 1'b0;
      busy      <= 1'b0;
    end else begin
      meter_b <= 1'b0;
      case (state)
        S_IDLE: begin
          if (req_valid && req_ready) begin
            cont_q    <= cont;
            acc       <= '0;
            shot_cnt  <= '0;
            state     <= S_ARM;
            meter_b   <= 1'b1;
            req_ready <= 1'b0;
            busy      <= 1'b1;
          end
        end
        S_ARM: begin
          to_cnt <= '0;
          state  <= S_WAIT_ECHO;
        end
        S_WAIT_ECHO: begin
          to_cnt <= to_cnt + TW'(1);
          if (sensor_s) begin
            state <= S_CAPTURE;
          end else if (to_cnt == TO_LAST) begin
            state     <= S_ERR_RST;
            meter_rst <= 1'b1;
            rst_cnt   <= '0;
            acc       <= '0;
            shot_cnt  <= '0;
          end
        end
        S_CAPTURE: begin
          acc      <= acc_sum;
          shot_cnt <= shot_cnt + SW'(1);
          if (shot_cnt == LAST_SHOT) begin
            state     <= S_DONE;
            res_valid <= 1'b1;
            res_err   <= 1'b0;
            res_dist  <= acc_sum[AW-1:LOG2_NAVG];
          end else begin
            state   <= S_GAP;
            gap_cnt <= '0;
          end
        end
        S_GAP: begin
          if (gap_cnt == GAP_LAST) begin
            state   <= S_ARM;
            meter_b <= 1'b1;
          end else begin
            gap_cnt <= gap_cnt + GW'(1);
          end
        end
        S_DONE: begin
          if (res_ready) begin
            res_valid <= 1'b0;
            res_dist  <= '0;
            if (cont_q && req_valid) begin
              acc      <= '0;
              shot_cnt <= '0;
              gap_cnt  <= '0;
              state    <= S_GAP;
            end else begin
              state     <= S_IDLE;
              req_ready <= 1'b1;
              busy      <= 1'b0;
            end
          end
        end
        S_ERR_RST: begin
          if (rst_cnt == RST_LAST) begin
            meter_rst <= 1'b0;
            state     <= S_ERR_HOLD;
            res_valid <= 1'b1;
            res_err   <= 1'b1;
            res_dist  <= '0;
          end else begin
            rst_cnt <= rst_cnt + RW'(1);
          end
        end
        S_ERR_HOLD: begin
          if (res_ready) begin
            res_valid <= 1'b0;
            res_err   <= 1'b0;
            state     <= S_IDLE;
            req_ready <= 1'b1;
            busy      <= 1'b0;
          end
        end
        default: begin
          state     <= S_IDLE;
          req_ready <= 1'b1;
          busy      <= 1'b0;
          meter_rst <= 1'b0;
          res_valid <= 1'b0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_laser_measure_scheduler.sv
// Bench for laser_measure_scheduler: plans a whole run of requests as a per-cycle
// timeline (stimulus and expected outputs) from the scheduling rules, then plays
// it against the DUT and compares every cycle.
module tb_laser_measure_scheduler;

  localparam int DW   = 16;
  localparam int L    = 2;
  localparam int N    = 4;
  localparam int T    = 8;
  localparam int G    = 4;
  localparam int R    = 2;
  localparam int MAXC = 20000;

  logic          clk = 1'b0;
  logic          reset;
  logic          req_valid;
  logic          req_ready;
  logic          cont;
  logic          sensor_s;
  logic [DW-1:0] meas_d;
  logic          meter_b;
  logic          meter_rst;
  logic          res_valid;
  logic          res_ready;
  logic [DW-1:0] res_dist;
  logic          res_err;
  logic          busy;

  always #5 clk = ~clk;

  laser_measure_scheduler #(
    .DW(DW), .LOG2_NAVG(L), .TIMEOUT(T), .GAP(G), .RST_CYC(R)
  ) dut (
    .clk(clk), .reset(reset), .req_valid(req_valid), .req_ready(req_ready),
    .cont(cont), .sensor_s(sensor_s), .meas_d(meas_d), .meter_b(meter_b),
    .meter_rst(meter_rst), .res_valid(res_valid), .res_ready(res_ready),
    .res_dist(res_dist), .res_err(res_err), .busy(busy)
  );

  // stimulus timeline
  bit            s_req  [MAXC];
  bit            s_cont [MAXC];
  bit            s_rdy  [MAXC];
  byte           s_sens [MAXC];   // 0 free/noise, 1 forced low, 2 forced high
  logic [DW-1:0] s_meas [MAXC];
  // expected timeline
  bit            e_b    [MAXC];
  bit            e_rst  [MAXC];
  bit            e_valid[MAXC];
  bit            e_err  [MAXC];
  bit            e_busy [MAXC];
  logic [DW-1:0] e_dist [MAXC];

  int pc;
  int tests = 0;
  int fails = 0;
  int qd[$], qv[$], qbp[$];

  task automatic chk(input string nm, input int k, input logic [31:0] got, input logic [31:0] exp);
    tests++;
    if (got !== exp) begin
      fails++;
      if (fails <= 50) $display("FAIL %s cyc=%0d got=%0h exp=%0h", nm, k, got, exp);
    end
  endtask

  task automatic mark_busy(input int k);
    e_busy[k] = 1'b1;
    s_req[k]  = 1'($urandom % 2);
  endtask

  task automatic pick_shot(output int d, output int v);
    int r;
    if (qd.size() > 0) begin
      d = qd.pop_front();
      v = qv.pop_front();
    end else begin
      r = int'($urandom % 12);
      if (r == 0)      d = T;
      else if (r == 1) d = T - 1;
      else             d = int'($urandom_range(1, T - 2));
      v = int'($urandom % 65536);
    end
  endtask

  task automatic pick_bp(output int bp);
    if (qbp.size() > 0) bp = qbp.pop_front();
    else if ($urandom % 4 == 0) bp = int'($urandom_range(5, 12));
    else bp = int'($urandom_range(0, 2));
  endtask

  // One host request: nres results in continuous mode, 1 in single mode.
  task automatic plan_txn(input bit cont_v, input int nres);
    int a, d, v, r, e, bp, sum, npad;
    bit err;
    s_req[pc]  = 1'b1;
    s_cont[pc] = cont_v;
    a = pc + 1;
    r = 0;
    for (int i = 0; i < nres; i++) begin
      sum = 0;
      err = 1'b0;
      for (int s = 0; s < N; s++) begin
        mark_busy(a);
        e_b[a] = 1'b1;
        pick_shot(d, v);
        if (d >= T) begin
          for (int k = a + 1; k < a + T; k++) begin mark_busy(k); s_sens[k] = 1; end
          for (int k = a + T; k < a + T + R; k++) begin mark_busy(k); e_rst[k] = 1'b1; end
          r = a + T + R;
          err = 1'b1;
          break;
        end
        for (int k = a + 1; k < a + d; k++) begin mark_busy(k); s_sens[k] = 1; end
        mark_busy(a + d);
        s_sens[a + d] = 2;
        s_meas[a + d] = DW'(v);
        mark_busy(a + d + 1);
        s_meas[a + d + 1] = DW'(v);
        sum += v;
        if (s == N - 1) begin
          r = a + d + 2;
        end else begin
          for (int k = a + d + 2; k <= a + d + 1 + G; k++) mark_busy(k);
          a = a + d + 2 + G;
        end
      end
      pick_bp(bp);
      for (int k = r; k <= r + bp; k++) begin
        mark_busy(k);
        e_valid[k] = 1'b1;
        e_err[k]   = err;
        e_dist[k]  = err ? '0 : DW'(sum / N);
        s_rdy[k]   = (k == r + bp);
      end
      e = r + bp;
      if (!err && cont_v && i < nres - 1) begin
        s_req[e] = 1'b1;
        for (int k = e + 1; k <= e + G; k++) mark_busy(k);
        a = e + G + 1;
      end else begin
        s_req[e] = (cont_v && !err) ? 1'b0 : 1'($urandom % 2);
        pc = e + 1;
        break;
      end
    end
    npad = int'($urandom_range(0, 3));
    for (int j = 0; j < npad; j++) begin
      s_req[pc] = 1'b0;
      pc++;
    end
  endtask

  initial begin
    int endc, ntx;
    int b_cnt, last_b, rst_delta, rst_len, v_len, v_cyc;
    int b_first[2];
    logic [DW-1:0] v_dist;
    bit rst_done, v_done;

    for (int k = 0; k < MAXC; k++) begin
      s_req[k] = 1'b0; s_cont[k] = 1'($urandom % 2); s_rdy[k] = 1'($urandom % 2);
      s_sens[k] = 0; s_meas[k] = DW'($urandom);
      e_b[k] = 0; e_rst[k] = 0; e_valid[k] = 0; e_err[k] = 0; e_busy[k] = 0; e_dist[k] = '0;
    end

    // directed: averaged shots 10..13 (last echo on the final timeout cycle) with
    // long backpressure, then a timeout, then a continuous run
    qd = '{5, 6, 3, T - 1, T};
    qv = '{10, 11, 12, 13, 0};
    qbp = '{20, 0};
    pc = 0;
    plan_txn(1'b0, 1);
    plan_txn(1'b0, 1);
    plan_txn(1'b1, 3);
    ntx = 0;
    while (pc < MAXC - 1000 && ntx < 60) begin
      if ($urandom % 2 == 1) plan_txn(1'b1, int'($urandom_range(1, 3)));
      else                    plan_txn(1'b0, 1);
      ntx++;
    end
    endc = pc + 5;

    reset = 1'b1; req_valid = 0; cont = 0; sensor_s = 0; meas_d = '0; res_ready = 0;
    repeat (3) @(negedge clk);
    chk("rst_req_ready", -1, 32'(req_ready), 1);
    chk("rst_meter_b",   -1, 32'(meter_b),   0);
    chk("rst_meter_rst", -1, 32'(meter_rst), 0);
    chk("rst_res_valid", -1, 32'(res_valid), 0);
    chk("rst_res_dist",  -1, 32'(res_dist),  0);
    chk("rst_res_err",   -1, 32'(res_err),   0);
    chk("rst_busy",      -1, 32'(busy),      0);

    b_cnt = 0; last_b = -1; rst_delta = -1; rst_len = 0; rst_done = 0;
    v_len = 0; v_cyc = 0; v_dist = '0; v_done = 0; b_first[0] = 0; b_first[1] = 0;

    for (int k = 0; k < endc; k++) begin
      @(posedge clk);
      #1;
      if (k == 0) reset = 1'b0;
      req_valid = s_req[k];
      cont      = s_cont[k];
      res_ready = s_rdy[k];
      meas_d    = s_meas[k];
      sensor_s  = (s_sens[k] == 2) ? 1'b1 : (s_sens[k] == 1) ? 1'b0 : ($urandom % 4 == 0);
      @(negedge clk);
      chk("meter_b",   k, 32'(meter_b),   32'(e_b[k]));
      chk("meter_rst", k, 32'(meter_rst), 32'(e_rst[k]));
      chk("res_valid", k, 32'(res_valid), 32'(e_valid[k]));
      chk("busy",      k, 32'(busy),      32'(e_busy[k]));
      chk("req_ready", k, 32'(req_ready), 32'(!e_busy[k]));
      chk("b_rst_excl", k, 32'(meter_b & meter_rst), 0);
      if (e_valid[k]) begin
        chk("res_dist", k, 32'(res_dist), 32'(e_dist[k]));
        chk("res_err",  k, 32'(res_err),  32'(e_err[k]));
      end
      if (meter_b === 1'b1) begin
        if (b_cnt < 2) b_first[b_cnt] = k;
        b_cnt++;
        last_b = k;
      end
      if (meter_rst === 1'b1 && !rst_done) begin
        if (rst_delta < 0) rst_delta = k - last_b;
        rst_len++;
      end else if (rst_delta >= 0) rst_done = 1'b1;
      if (res_valid === 1'b1 && !v_done) begin
        if (v_len == 0) begin v_dist = res_dist; v_cyc = k; end
        v_len++;
      end else if (v_len > 0) v_done = 1'b1;
    end

    // hand-computed pins for the directed opening requests
    chk("pin_b_spacing", -1, 32'(b_first[1] - b_first[0]), 11);
    chk("pin_avg_dut",   -1, 32'(v_dist), 11);
    chk("pin_avg_model", -1, 32'(e_dist[v_cyc]), 11);
    chk("pin_bp_hold",   -1, 32'(v_len), 21);
    chk("pin_to_delay",  -1, 32'(rst_delta), 8);
    chk("pin_rst_len",   -1, 32'(rst_len), 2);

    // asynchronous reset while waiting for an echo
    @(posedge clk); #1;
    req_valid = 1'b1; cont = 1'b0; sensor_s = 1'b0; res_ready = 1'b1;
    @(posedge clk); #1;
    req_valid = 1'b0;
    @(negedge clk);
    chk("mid_arm_b", -1, 32'(meter_b), 1);
    @(posedge clk);
    @(posedge clk); #2;
    chk("mid_pre_busy", -1, 32'(busy), 1);
    reset = 1'b1;
    #1;
    chk("mid_req_ready", -1, 32'(req_ready), 1);
    chk("mid_meter_b",   -1, 32'(meter_b),   0);
    chk("mid_meter_rst", -1, 32'(meter_rst), 0);
    chk("mid_res_valid", -1, 32'(res_valid), 0);
    chk("mid_res_dist",  -1, 32'(res_dist),  0);
    chk("mid_res_err",   -1, 32'(res_err),   0);
    chk("mid_busy",      -1, 32'(busy),      0);
    @(posedge clk); #1;
    reset = 1'b0;
    sensor_s = 1'b1;
    for (int k = 0; k < 20; k++) begin
      @(negedge clk);
      chk("post_rst_valid", k, 32'(res_valid), 0);
      chk("post_rst_busy",  k, 32'(busy),      0);
      chk("post_rst_b",     k, 32'(meter_b),   0);
      sensor_s = 1'b0;
    end

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
